// File: rtl/apb_master_arbiter_pkg.sv
// Shared types for the APB master arbiter slice.
//   apb_state_e : APB master sequencer states
//   APB_PROT_W  : PPROT width
//   strb_w()    : PSTRB width for a given data width
package apb_master_arbiter_pkg;
  localparam int APB_PROT_W = 3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the master sequencer and the fabric/completer.
//   master modport : drives PADDR/PPROT/PSEL/PENABLE/PWRITE/PWDATA/PSTRB,
//                    receives PREADY/PRDATA/PSLVERR
//   slave modport  : mirror image, for completer models / checkers
interface apb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import apb_master_arbiter_pkg::*;

  logic [ADDR_WIDTH-1:0]           PADDR;
  logic [APB_PROT_W-1:0]           PPROT;
  logic                            PSEL;
  logic                            PENABLE;
  logic                            PWRITE;
  logic [DATA_WIDTH-1:0]           PWDATA;
  logic [strb_w(DATA_WIDTH)-1:0]   PSTRB;
  logic                            PREADY;
  logic [DATA_WIDTH-1:0]           PRDATA;
  logic                            PSLVERR;

  modport master (
    output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Round-robin arbiter.
//   PCLK/PRESETn : clock, synchronous active-low reset
//   req          : request vector
//   advance      : grant taken this cycle; pointer moves past the winner
//   gnt/gnt_idx  : one-hot grant and its index (combinational)
//   gnt_any      : at least one request present
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                                    PCLK,
  input  logic                                    PRESETn,
  input  logic [NUM_REQ-1:0]                      req,
  input  logic                                    advance,
  output logic [NUM_REQ-1:0]                      gnt,
  output logic [(NUM_REQ>1?$clog2(NUM_REQ):1)-1:0] gnt_idx,
  output logic                                    gnt_any
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] ptr_q;
  int            idx;

  // Search starts at the pointer and wraps; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[IW-1:0];
      end
    end
    gnt[gnt_idx] = gnt_any;
  end

  // With a single requester gnt_idx is always 0 == NUM_REQ-1, so ptr stays 0.
  always_ff @(posedge PCLK) begin
    if (!PRESETn)                ptr_q <= '0;
    else if (advance && gnt_any) ptr_q <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter + APB master sequencer sharing one APB port among NUM_REQ requesters.
//   PCLK/PRESETn     : clock, synchronous active-low reset
//   req_*            : per-requester request payload (req 0 in LSBs), req_ready accept pulse
//   rsp_valid        : one-hot completion pulse; rsp_rdata/rsp_err valid alongside
//   apb              : APB master port (interface, master modport)
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_W     = strb_w(DATA_WIDTH)
) (
  input  logic                                     PCLK,
  input  logic                                     PRESETn,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_REQ-1:0]                       req_write,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]       req_wdata,
  input  logic [NUM_REQ-1:0][STRB_W-1:0]           req_strb,
  input  logic [NUM_REQ-1:0][APB_PROT_W-1:0]       req_prot,
  output logic [NUM_REQ-1:0]                       rsp_valid,
  output logic [DATA_WIDTH-1:0]                    rsp_rdata,
  output logic                                     rsp_err,
  apb_master_arbiter_if.master                     apb
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  apb_state_e               state_q, state_d;
  logic [NUM_REQ-1:0]       gnt;
  logic [IW-1:0]            gnt_idx, owner_q;
  logic                     gnt_any, grant_point, done;
  logic                     psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0]    paddr_q;
  logic [DATA_WIDTH-1:0]    pwdata_q;
  logic [STRB_W-1:0]        pstrb_q;
  logic [APB_PROT_W-1:0]    pprot_q;

  assign done        = (state_q == ACCESS) && apb.PREADY;
  assign grant_point = (state_q == IDLE) || done;
  assign req_ready   = gnt & {NUM_REQ{grant_point}};

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .req     (req_valid),
    .advance (grant_point),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb.PREADY) state_d = gnt_any ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // PSEL/PENABLE are flopped from next state so the APB side is glitch-free.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      owner_q   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= (state_d != IDLE);
      penable_q <= (state_d == ACCESS);
      if (grant_point && gnt_any) begin
        paddr_q  <= req_addr[gnt_idx];
        pwrite_q <= req_write[gnt_idx];
        pwdata_q <= req_write[gnt_idx] ? req_wdata[gnt_idx] : '0;
        pstrb_q  <= req_write[gnt_idx] ? req_strb[gnt_idx]  : '0;
        pprot_q  <= req_prot[gnt_idx];
        owner_q  <= gnt_idx;
      end
      rsp_valid <= '0;
      if (done) begin
        rsp_valid[owner_q] <= 1'b1;
        rsp_rdata          <= pwrite_q ? '0 : apb.PRDATA;
        rsp_err            <= apb.PSLVERR;
      end
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;
  assign apb.PPROT   = pprot_q;
endmodule
